// File: rtl/keypad_debounce_fifo.sv
// keypad_debounce_fifo: debounces keypad codes into one event per press and queues them for a valid/ready consumer.
module keypad_debounce_fifo #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEPTH           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       key_ready,
    input  logic       flush,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]  cap_q, cap_d;
    logic        active, push;
    logic [3:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0] count_q;
    logic        pop, push_ok, drop;

    assign active  = key_in <= 4'd11;
    assign cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (active) begin
                state_d = PRESS_WAIT;
                cap_d   = key_in;
                cnt_d   = 8'd1;
            end
            PRESS_WAIT: if (!active) state_d = IDLE;
                else if (key_in != cap_q) begin
                    cap_d = key_in;
                    cnt_d = 8'd1;
                end else if (cnt_q == LAST) begin
                    state_d = HELD;
                    push    = 1'b1;
                end else cnt_d = cnt_inc;
            HELD: if (!active) begin
                state_d = RELEASE_WAIT;
                cnt_d   = 8'd1;
            end
            RELEASE_WAIT: if (active) state_d = HELD;
                else if (cnt_q == LAST) state_d = IDLE;
                else cnt_d = cnt_inc;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end

    // flush wins over both push and pop in its cycle
    assign key_valid = count_q != '0;
    assign fifo_full = count_q == (AW+1)'(DEPTH);
    assign pop       = key_valid & key_ready & ~flush;
    assign push_ok   = push & ~flush & (~fifo_full | pop);
    assign drop      = push & ~flush & fifo_full & ~pop;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_q     <= wr_q;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (drop) overflow <= 1'b1;
        end

    always_ff @(posedge clk)
        if (push_ok) mem_q[wr_q] <= cap_q;

    assign key_code = key_valid ? mem_q[rd_q] : 4'h0;
    assign key_held = (state_q == HELD) || (state_q == RELEASE_WAIT);
endmodule
